// File: rtl/resim_pkg.sv
// rtl/resim_pkg.sv - shared widths, state encoding and default frame length
package resim_pkg;
  localparam int PIKSEL_W             = 3;
  localparam int FILTRE_W             = 5;
  localparam int FRAME_LEN_VARSAYILAN = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } durum_e;
endpackage

// File: rtl/resim_filtreleyici.sv
// rtl/resim_filtreleyici.sv - combinational pixel filter: out = 3*piksel + 1
module resim_filtreleyici
  import resim_pkg::*;
(
  input  logic [PIKSEL_W-1:0] piksel_i,
  output logic [FILTRE_W-1:0] filtre_o
);
  logic [FILTRE_W-1:0] genis;

  assign genis    = FILTRE_W'(piksel_i);
  assign filtre_o = (genis << 1) + genis + FILTRE_W'(1);
endmodule

// File: rtl/resim_filtre_denetleyici.sv
// rtl/resim_filtre_denetleyici.sv - two-source frame arbiter sharing one pixel filter
module resim_filtre_denetleyici
  import resim_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_VARSAYILAN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s0_valid,
  input  logic [PIKSEL_W-1:0] s0_piksel,
  output logic                s0_ready,
  input  logic                s1_valid,
  input  logic [PIKSEL_W-1:0] s1_piksel,
  output logic                s1_ready,
  output logic                out_valid,
  output logic [FILTRE_W-1:0] out_filtre,
  output logic                out_kaynak,
  output logic                out_son,
  input  logic                out_ready,
  output logic                mesgul
);
  localparam int SAYAC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [SAYAC_W-1:0] SON_SAYAC = SAYAC_W'(FRAME_LEN - 1);

  durum_e              state_q, state_d;
  logic [SAYAC_W-1:0]  sayac_q, sayac_d;
  logic                son_grant_q, son_grant_d;
  logic                out_valid_q, out_valid_d;
  logic [FILTRE_W-1:0] out_filtre_q, out_filtre_d;
  logic                out_kaynak_q, out_kaynak_d;
  logic                out_son_q, out_son_d;
  logic                mesgul_q;

  logic                hs0, hs1, son_piksel;
  logic [PIKSEL_W-1:0] secili_piksel;
  logic [FILTRE_W-1:0] filtre;

  assign secili_piksel = (state_q == BUSY1) ? s1_piksel : s0_piksel;

  resim_filtreleyici u_filtre (
    .piksel_i (secili_piksel),
    .filtre_o (filtre)
  );

  // Ready depends only on state and the output slot, never on the source valid.
  assign s0_ready   = (state_q == BUSY0) && (!out_valid_q || out_ready);
  assign s1_ready   = (state_q == BUSY1) && (!out_valid_q || out_ready);
  assign hs0        = s0_ready && s0_valid;
  assign hs1        = s1_ready && s1_valid;
  assign son_piksel = (sayac_q == SON_SAYAC);

  always_comb begin
    state_d      = state_q;
    sayac_d      = sayac_q;
    son_grant_d  = son_grant_q;
    out_valid_d  = out_valid_q;
    out_filtre_d = out_filtre_q;
    out_kaynak_d = out_kaynak_q;
    out_son_d    = out_son_q;

    if (hs0 || hs1) begin
      out_valid_d  = 1'b1;
      out_filtre_d = filtre;
      out_kaynak_d = hs1;
      out_son_d    = son_piksel;
      if (son_piksel) begin
        sayac_d     = '0;
        son_grant_d = hs1;
        state_d     = IDLE;
      end else begin
        sayac_d = sayac_q + SAYAC_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // On a tie the source that did not own the previous frame wins.
        if (s0_valid && s1_valid) state_d = son_grant_q ? BUSY0 : BUSY1;
        else if (s0_valid)        state_d = BUSY0;
        else if (s1_valid)        state_d = BUSY1;
      end
      BUSY0, BUSY1: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sayac_q      <= '0;
      son_grant_q  <= 1'b1;
      out_valid_q  <= 1'b0;
      out_filtre_q <= '0;
      out_kaynak_q <= 1'b0;
      out_son_q    <= 1'b0;
      mesgul_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sayac_q      <= sayac_d;
      son_grant_q  <= son_grant_d;
      out_valid_q  <= out_valid_d;
      out_filtre_q <= out_filtre_d;
      out_kaynak_q <= out_kaynak_d;
      out_son_q    <= out_son_d;
      mesgul_q     <= (state_d != IDLE);
    end
  end

  assign out_valid  = out_valid_q;
  assign out_filtre = out_filtre_q;
  assign out_kaynak = out_kaynak_q;
  assign out_son    = out_son_q;
  assign mesgul     = mesgul_q;
endmodule
